auv_fetch_buf: RTL and testbench

Prefetching instruction fetch unit with a parametrised instruction queue and a pipelined, variable-latency memory port. It sits between the instruction memory (boot ROM or bus) and decode, keeping up to DEPTH fetches in flight or buffered. It hands decode one {instruction, PC} pair per valid/ready handshake. Redirects from execute flush the queue and silently discard stale in-flight responses.

---
 rtl/auv_pkg.sv | 8 +
 rtl/auv_fifo.sv | 55 +++++
 rtl/auv_fetch_buf.sv | 100 ++++++++++
 tb/tb_auv_fetch_buf.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/auv_pkg.sv
// Shared constants and types for the auv fetch path.
package auv_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef logic [31:0] inst_t;

endpackage

// File: rtl/auv_fifo.sv
// Synchronous FIFO with flush; head is the oldest entry, valid while count != 0.
module auv_fifo
    import auv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd;
    logic [AW-1:0]    wr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop)  rd <= rd + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd];

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && !pop && count == (AW+1)'(DEPTH)));

endmodule

// File: rtl/auv_fetch_buf.sv
// Prefetching fetch unit: credit-limited requests to a pipelined memory,
// responses queued for decode, stale responses dropped after a redirect.
module auv_fetch_buf
    import auv_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 24,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-3:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jmp,
    input  logic [ADDR_WIDTH-3:0] pc_wr,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [ADDR_WIDTH-3:0] inst_pc,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-3:0] mem_adr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    localparam int PW = ADDR_WIDTH - 2;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        inst_t         inst;
        logic [PW-1:0] pc;
    } fetch_t;

    logic [PW-1:0] fpc;
    logic [PW-1:0] rpc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [CW:0]   inflight;
    fetch_t        wr_ent;
    fetch_t        head;
    logic          grant;
    logic          live;
    logic          push;
    logic          pop;

    assign inflight = {1'b0, count} + {1'b0, outstanding};
    assign mem_req  = !rst && !jmp && (inflight < (CW+1)'(DEPTH));
    assign mem_adr  = fpc;
    assign grant    = mem_req && mem_gnt;
    assign live     = mem_rvalid && (drop == '0);
    assign push     = live && !jmp;
    assign pop      = inst_valid && inst_ready;

    assign wr_ent.inst = mem_rdata;
    assign wr_ent.pc   = rpc;

    auv_fifo #(
        .WIDTH ($bits(fetch_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (jmp),
        .push  (push),
        .din   (wr_ent),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    assign inst_valid = (count != '0) && !jmp;
    assign inst       = inst_valid ? head.inst : INST_NOP;
    assign inst_pc    = inst_valid ? head.pc : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc         <= RESET_PC;
            rpc         <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(mem_rvalid);
            if (jmp) begin
                fpc <= pc_wr;
                rpc <= pc_wr;
                // Everything still in flight is stale, including any already
                // marked for dropping; outstanding counts them all.
                drop <= outstanding - CW'(mem_rvalid);
            end else begin
                if (grant) fpc <= fpc + 1'b1;
                if (live)  rpc <= rpc + 1'b1;
                if (mem_rvalid && drop != '0) drop <= drop - 1'b1;
            end
        end
    end

    a_rvalid_expected : assert property (@(posedge clk) disable iff (rst)
        mem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_auv_fetch_buf.sv
// Self-checking bench for auv_fetch_buf: fixed-latency memory model,
// scoreboard of expected {inst, pc} pairs, table plus corner sequences.
module tb_auv_fetch_buf;
    import auv_pkg::*;

    localparam int AW    = 24;
    localparam int PW    = AW - 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          jmp;
    logic [PW-1:0] pc_wr;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst;
    logic [PW-1:0] inst_pc;
    logic          mem_req;
    logic [PW-1:0] mem_adr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;

    auv_fetch_buf #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .RESET_PC   ('0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .jmp        (jmp),
        .pc_wr      (pc_wr),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .mem_req    (mem_req),
        .mem_adr    (mem_adr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] adr;
        int            due;
    } req_t;

    typedef struct {
        logic [31:0]   inst;
        logic [PW-1:0] pc;
    } exp_t;

    typedef struct {
        logic          ready;
        logic          req;
        logic [PW-1:0] adr;
        logic          valid;
        logic [PW-1:0] pc;
    } vec_t;

    req_t          pend[$];
    exp_t          sb[$];
    vec_t          vecs[8];
    int            errors = 0;
    int            checks = 0;
    int            cnum   = 0;
    int            lat    = 1;
    int            grants = 0;
    int            pops   = 0;
    logic [PW-1:0] exp_fpc = '0;
    logic          popped = 1'b0;
    logic [PW-1:0] pop_pc = '0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cyc();
        exp_t e;
        popped     = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (rst) begin
            pend.delete();
        end else if (pend.size() != 0 && pend[0].due <= cnum) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h100 + 32'(pend[0].adr);
            void'(pend.pop_front());
        end
        #1;
        if (rst) begin
            sb.delete();
            exp_fpc = '0;
        end else begin
            if (jmp) begin
                chk("jmp_valid", 64'(inst_valid), 64'(0));
                chk("jmp_req", 64'(mem_req), 64'(0));
            end
            if (!inst_valid) begin
                chk("idle_nop", 64'(inst), 64'(INST_NOP));
                chk("idle_pc", 64'(inst_pc), 64'(0));
            end
            if (mem_req && mem_gnt) begin
                chk("mem_adr", 64'(mem_adr), 64'(exp_fpc));
                pend.push_back('{adr: mem_adr, due: cnum + lat});
                sb.push_back('{inst: 32'h100 + 32'(exp_fpc), pc: exp_fpc});
                exp_fpc = exp_fpc + 1'b1;
                grants++;
            end
            if (inst_valid && inst_ready) begin
                popped = 1'b1;
                pop_pc = inst_pc;
                pops++;
                chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("inst", 64'(inst), 64'(e.inst));
                    chk("inst_pc", 64'(inst_pc), 64'(e.pc));
                end
            end
            if (jmp) begin
                sb.delete();
                exp_fpc = pc_wr;
            end
        end
        @(posedge clk);
        cnum++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        jmp        = 1'b0;
        inst_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_pop(input string name, output logic [PW-1:0] pc,
                            output int n);
        logic got;
        got = 1'b0;
        pc  = '0;
        n   = -1;
        for (int k = 0; k < 20 && !got; k++) begin
            cyc();
            if (popped) begin
                got = 1'b1;
                pc  = pop_pc;
                n   = k;
            end
        end
        chk({name, "_timeout"}, 64'(got), 64'(1));
    endtask

    initial begin
        logic [PW-1:0] pc;
        int            n;
        int            g0;
        int            p0;

        for (int i = 0; i < 8; i++) begin
            vecs[i].ready = 1'b1;
            vecs[i].req   = 1'b1;
            vecs[i].adr   = PW'(i);
            vecs[i].valid = (i >= 2);
            vecs[i].pc    = (i >= 2) ? PW'(i - 2) : '0;
        end

        rst        = 1'b1;
        jmp        = 1'b0;
        pc_wr      = '0;
        inst_ready = 1'b0;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        @(negedge clk);
        #1;
        chk("rst_valid", 64'(inst_valid), 64'(0));
        chk("rst_inst", 64'(inst), 64'(INST_NOP));
        chk("rst_pc", 64'(inst_pc), 64'(0));
        chk("rst_req", 64'(mem_req), 64'(0));
        chk("rst_adr", 64'(mem_adr), 64'(0));
        cyc();
        rst = 1'b0;

        // Streaming from reset, 1-cycle memory, no bubbles.
        for (int i = 0; i < 8; i++) begin
            inst_ready = vecs[i].ready;
            #1;
            chk("vec_req", 64'(mem_req), 64'(vecs[i].req));
            chk("vec_adr", 64'(mem_adr), 64'(vecs[i].adr));
            chk("vec_valid", 64'(inst_valid), 64'(vecs[i].valid));
            chk("vec_pc", 64'(inst_pc), 64'(vecs[i].pc));
            cyc();
        end

        // Backpressure: exactly DEPTH grants, then drain in order.
        do_reset();
        lat = 1;
        g0  = grants;
        repeat (8) cyc();
        chk("stall_grants", 64'(grants - g0), 64'(DEPTH));
        chk("stall_req", 64'(mem_req), 64'(0));
        chk("stall_count", 64'(dut.u_fifo.count), 64'(DEPTH));
        inst_ready = 1'b1;
        p0 = pops;
        repeat (4) cyc();
        chk("drain_pops", 64'(pops - p0), 64'(4));
        chk("resume", 64'(grants - g0 > DEPTH), 64'(1));

        // Redirect with three 3-cycle requests in flight.
        do_reset();
        lat        = 3;
        inst_ready = 1'b1;
        repeat (3) cyc();
        chk("jl_outstanding", 64'(dut.outstanding), 64'(3));
        jmp   = 1'b1;
        pc_wr = PW'('h40);
        cyc();
        jmp = 1'b0;
        #1;
        chk("jl_req_after", 64'(mem_req), 64'(1));
        chk("jl_adr_after", 64'(mem_adr), 64'('h40));
        chk("jl_drop", 64'(dut.drop), 64'(2));
        wait_pop("jl_pop", pc, n);
        chk("jl_first_pc", 64'(pc), 64'('h40));
        chk("jl_drop_done", 64'(dut.drop), 64'(0));

        // Redirect colliding with a response and a pop, count=2.
        do_reset();
        lat = 2;
        repeat (4) cyc();
        chk("jc_count", 64'(dut.u_fifo.count), 64'(2));
        inst_ready = 1'b1;
        jmp        = 1'b1;
        pc_wr      = PW'('h80);
        cyc();
        jmp = 1'b0;
        #1;
        chk("jc_empty", 64'(inst_valid), 64'(0));
        chk("jc_drop", 64'(dut.drop), 64'(1));
        chk("jc_outst", 64'(dut.outstanding), 64'(1));
        p0 = pops;
        wait_pop("jc_pop", pc, n);
        chk("jc_first_pc", 64'(pc), 64'('h80));
        chk("jc_one_pop", 64'(pops - p0), 64'(1));

        // PC wrap at the top of the word-address space.
        do_reset();
        lat        = 1;
        inst_ready = 1'b1;
        jmp        = 1'b1;
        pc_wr      = '1;
        cyc();
        jmp = 1'b0;
        wait_pop("wrap_pop0", pc, n);
        chk("wrap_pc0", 64'(pc), 64'(22'h3F_FFFF));
        chk("jmp_latency", 64'(n), 64'(2));
        wait_pop("wrap_pop1", pc, n);
        chk("wrap_pc1", 64'(pc), 64'(0));
        chk("wrap_gap", 64'(n), 64'(0));

        // Reset asserted mid-stream with two entries queued.
        do_reset();
        lat = 1;
        repeat (3) cyc();
        chk("mr_count", 64'(dut.u_fifo.count), 64'(2));
        rst = 1'b1;
        #1;
        chk("mr_valid", 64'(inst_valid), 64'(0));
        chk("mr_req", 64'(mem_req), 64'(0));
        chk("mr_adr", 64'(mem_adr), 64'(0));
        cyc();
        cyc();
        rst        = 1'b0;
        inst_ready = 1'b1;
        #1;
        chk("mr_req_rel", 64'(mem_req), 64'(1));
        chk("mr_adr_rel", 64'(mem_adr), 64'(0));
        wait_pop("mr_pop", pc, n);
        chk("mr_first_pc", 64'(pc), 64'(0));
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
